// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants and FSM encoding for the fetch stage
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_unit_queue.sv
// rtl/fetch_unit_queue.sv - fetch queue of {pc, inst} pairs with combinational head
module fetch_queue #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [31:0]                i_push_pc,
  input  logic [31:0]                i_push_inst,
  input  logic                       i_pop,
  input  logic                       i_clear,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty,
  output logic [31:0]                o_head_pc,
  output logic [31:0]                o_head_inst
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [31:0]   r_pc_mem   [DEPTH];
  logic [31:0]   r_inst_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  // Clear wins over both push and pop so a flush never leaves a stale entry.
  assign w_do_pop  = i_pop & ~i_clear & (r_count != '0);
  assign w_do_push = i_push & ~i_clear & ((r_count != CNT_FULL) | w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_pc_mem[r_wr_ptr]   <= i_push_pc;
      r_inst_mem[r_wr_ptr] <= i_push_inst;
    end
  end

  assign o_count     = r_count;
  assign o_empty     = (r_count == '0);
  assign o_head_pc   = r_pc_mem[r_rd_ptr];
  assign o_head_inst = r_inst_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, one-outstanding imem requests, fetch queue
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_pcadd4,
  output logic [31:0] if_inst,
  output logic        if_commit
);

  localparam int          AW       = $clog2(FQ_DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(FQ_DEPTH);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;
  logic [31:0]  r_last_pc;
  logic [31:0]  w_issue_addr;
  logic [31:0]  w_head_pc;
  logic [31:0]  w_head_inst;
  logic [AW:0]  w_count;
  logic [AW:0]  w_occ;
  logic         w_empty;
  logic         w_consume;
  logic         w_push;
  logic         w_room;
  logic         w_issue;

  assign w_consume = ~w_empty & ~stall & ~redirect;
  assign w_push    = ~redirect & (r_state == S_WAIT) & imem_valid;

  // Occupancy after this edge; a new request may only leave if its reply is sure to fit.
  assign w_occ  = w_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_consume};
  assign w_room = (w_occ < CNT_FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_REQ;
      r_pc      <= RESET_PC;
      r_last_pc <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_consume) r_last_pc <= w_head_pc;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_issue      = 1'b0;
    w_issue_addr = r_pc;
    if (redirect) begin
      w_pc_nxt = word_align(redirect_pc);
      case (r_state)
        S_WAIT:  w_state_nxt = imem_valid ? S_REQ : S_DROP;
        S_DROP:  w_state_nxt = imem_valid ? S_REQ : S_DROP;
        default: w_state_nxt = S_REQ;
      endcase
    end else begin
      case (r_state)
        S_REQ: begin
          w_issue = w_room;
          if (w_issue) w_state_nxt = S_WAIT;
        end
        S_WAIT: begin
          // r_pc tracks the outstanding address, so a chained request uses r_pc + 4.
          if (imem_valid) begin
            w_pc_nxt     = r_pc + 32'd4;
            w_issue_addr = r_pc + 32'd4;
            w_issue      = w_room;
            w_state_nxt  = w_room ? S_WAIT : S_REQ;
          end
        end
        S_DROP: begin
          if (imem_valid) w_state_nxt = S_REQ;
        end
        default: w_state_nxt = S_REQ;
      endcase
    end
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_pc   (r_pc),
    .i_push_inst (imem_rdata),
    .i_pop       (w_consume),
    .i_clear     (redirect),
    .o_count     (w_count),
    .o_empty     (w_empty),
    .o_head_pc   (w_head_pc),
    .o_head_inst (w_head_inst)
  );

  assign imem_req  = w_issue & ~rst;
  assign imem_addr = w_issue_addr;
  assign if_commit = ~w_empty;
  assign if_pc     = w_empty ? r_last_pc : w_head_pc;
  assign if_inst   = w_empty ? INST_NOP : w_head_inst;
  assign if_pcadd4 = if_pc + 32'd4;

endmodule
